float_to_int: RTL and testbench

Converts an IEEE-754 single-precision value to a signed 32-bit two's-complement integer, rounding toward zero and saturating at the integer range. It sits directly downstream of the FP multiplier in the ALU: `ia`/`i_stb` connect to the multiplier's `o_z`/`o_z_stb`, and `i_ack` drives the multiplier's `o_z_ack`. The result leaves on the same strobe/ack handshake used across the ALU. It is a multi-cycle state machine with an iterative shifter, not a pipeline.

---
 rtl/float_to_int.sv | 138 +++++++++++++
 tb/tb_float_to_int.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/float_to_int.sv
// IEEE-754 single to signed 32-bit integer: truncates toward zero, saturates at the int range.
// Multi-cycle FSM with a one-bit-per-cycle right shifter and strobe/ack handshakes on both sides.
module float_to_int #(
    parameter logic [31:0] NAN_VALUE = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ia,
    input  logic        i_stb,
    output logic        i_ack,
    output logic [31:0] o_z,
    output logic        o_z_stb,
    input  logic        o_z_ack
);

    typedef enum logic [2:0] {
        StGetA,
        StUnpack,
        StSpecial,
        StConvert,
        StPack,
        StSetZ
    } state_t;

    state_t             r_state, w_state;
    logic [31:0]        r_a, w_a;
    logic [31:0]        r_m, w_m;
    logic signed [9:0]  r_e, w_e;
    logic               r_s, w_s;
    logic [31:0]        r_z, w_z;
    logic               r_i_ack, w_i_ack;
    logic               r_o_z_stb, w_o_z_stb;
    logic [31:0]        r_o_z, w_o_z;

    logic [7:0]         w_exp;
    logic [22:0]        w_mant;

    assign w_exp  = r_a[30:23];
    assign w_mant = r_a[22:0];

    always_comb begin
        w_state   = r_state;
        w_a       = r_a;
        w_m       = r_m;
        w_e       = r_e;
        w_s       = r_s;
        w_z       = r_z;
        w_i_ack   = r_i_ack;
        w_o_z_stb = r_o_z_stb;
        w_o_z     = r_o_z;

        case (r_state)
            StGetA: begin
                w_i_ack = 1'b1;
                if (r_i_ack && i_stb) begin
                    w_a     = ia;
                    w_i_ack = 1'b0;
                    w_state = StUnpack;
                end
            end
            StUnpack: begin
                // m holds 1.mant scaled by 2^31; shifting to e = 31 leaves the integer part
                w_m     = {1'b1, r_a[22:0], 8'b0};
                w_e     = {2'b00, r_a[30:23]} - 10'd127;
                w_s     = r_a[31];
                w_state = StSpecial;
            end
            StSpecial: begin
                if (w_exp == 8'hFF && w_mant != 23'd0) begin
                    w_z     = NAN_VALUE;
                    w_state = StSetZ;
                end else if (w_exp == 8'd0) begin
                    w_z     = 32'd0;
                    w_state = StSetZ;
                end else if (r_e > 10'sd30) begin
                    w_z     = r_s ? 32'h80000000 : 32'h7FFFFFFF;
                    w_state = StSetZ;
                end else if (r_e < 10'sd0) begin
                    w_z     = 32'd0;
                    w_state = StSetZ;
                end else begin
                    w_state = StConvert;
                end
            end
            StConvert: begin
                if (r_e != 10'sd31) begin
                    w_m = r_m >> 1;
                    w_e = r_e + 10'sd1;
                end else begin
                    w_state = StPack;
                end
            end
            StPack: begin
                w_z     = r_s ? (~r_m + 32'd1) : r_m;
                w_state = StSetZ;
            end
            StSetZ: begin
                if (r_o_z_stb && o_z_ack) begin
                    w_o_z_stb = 1'b0;
                    w_state   = StGetA;
                end else begin
                    w_o_z_stb = 1'b1;
                    w_o_z     = r_z;
                end
            end
            default: w_state = StGetA;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StGetA;
            r_a       <= 32'd0;
            r_m       <= 32'd0;
            r_e       <= 10'sd0;
            r_s       <= 1'b0;
            r_z       <= 32'd0;
            r_i_ack   <= 1'b0;
            r_o_z_stb <= 1'b0;
            r_o_z     <= 32'd0;
        end else begin
            r_state   <= w_state;
            r_a       <= w_a;
            r_m       <= w_m;
            r_e       <= w_e;
            r_s       <= w_s;
            r_z       <= w_z;
            r_i_ack   <= w_i_ack;
            r_o_z_stb <= w_o_z_stb;
            r_o_z     <= w_o_z;
        end
    end

    assign i_ack   = r_i_ack;
    assign o_z_stb = r_o_z_stb;
    assign o_z     = r_o_z;

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed vector table, corner sequences and
// randomized operands checked against an arithmetic reference model.
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ia = 32'd0;
    logic        i_stb = 1'b0;
    logic        i_ack;
    logic [31:0] o_z;
    logic        o_z_stb;
    logic        o_z_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cap_cnt  = 0;
    int out_cnt  = 0;

    always #5 clk = ~clk;

    float_to_int #(.NAN_VALUE(32'h80000000)) dut (
        .clk     (clk),
        .rst     (rst),
        .ia      (ia),
        .i_stb   (i_stb),
        .i_ack   (i_ack),
        .o_z     (o_z),
        .o_z_stb (o_z_stb),
        .o_z_ack (o_z_ack)
    );

    // Transfer monitor on both handshakes
    always @(posedge clk) begin
        if (i_ack && i_stb) cap_cnt++;
        if (o_z_stb && o_z_ack) out_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value = 1.mant * 2^(exp-127), truncated toward zero
    function automatic logic [31:0] ref_z(input logic [31:0] x);
        int     ex;
        int     e;
        longint mag;
        ex = int'(x[30:23]);
        e  = ex - 127;
        if (ex == 255 && x[22:0] != 23'd0) return 32'h80000000;
        if (ex == 0) return 32'd0;
        if (e > 30) return x[31] ? 32'h80000000 : 32'h7FFFFFFF;
        if (e < 0) return 32'd0;
        mag = longint'({1'b1, x[22:0]});
        if (e >= 23) mag = mag << (e - 23);
        else         mag = mag >> (23 - e);
        if (x[31]) mag = -mag;
        return mag[31:0];
    endfunction

    function automatic int ref_lat(input logic [31:0] x);
        int ex;
        int e;
        ex = int'(x[30:23]);
        e  = ex - 127;
        if (ex == 255 || ex == 0 || e > 30 || e < 0) return 3;
        return 36 - e;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_i_ack(input string name);
        int waitc = 0;
        while (!i_ack && waitc < 100) begin
            step();
            waitc++;
        end
        check({name, " accept"}, {31'd0, i_ack}, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] exp_z,
                          input int exp_lat, input int ack_dly, input bit hold_ack);
        int          lat = 0;
        logic [31:0] zv;
        wait_i_ack(name);
        if (!i_ack) return;
        ia    = x;
        i_stb = 1'b1;
        step();
        i_stb = 1'b0;
        ia    = $urandom;
        if (hold_ack) o_z_ack = 1'b1;
        while (!o_z_stb && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({name, " latency"}, lat, exp_lat);
        zv = o_z;
        check({name, " value"}, zv, exp_z);
        if (!hold_ack) begin
            for (int k = 0; k < ack_dly; k++) step();
            if (ack_dly > 0) check({name, " stable"}, o_z, zv);
        end
        o_z_ack = 1'b1;
        step();
        o_z_ack = 1'b0;
        check({name, " stb drop"}, {31'd0, o_z_stb}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] z;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int          c0;
        int          o0;
        int          lat;
        logic [31:0] zv;
        logic [31:0] x;

        vecs[0]  = '{32'h3F800000, 32'h00000001, 36};
        vecs[1]  = '{32'h40200000, 32'h00000002, 35};
        vecs[2]  = '{32'hC0700000, 32'hFFFFFFFD, 35};
        vecs[3]  = '{32'h4EFFFFFF, 32'h7FFFFF80, 6};
        vecs[4]  = '{32'h4F000000, 32'h7FFFFFFF, 3};
        vecs[5]  = '{32'hCF000000, 32'h80000000, 3};
        vecs[6]  = '{32'hFF800000, 32'h80000000, 3};
        vecs[7]  = '{32'h7F800000, 32'h7FFFFFFF, 3};
        vecs[8]  = '{32'h7FC00000, 32'h80000000, 3};
        vecs[9]  = '{32'h00000001, 32'h00000000, 3};
        vecs[10] = '{32'h80000000, 32'h00000000, 3};
        vecs[11] = '{32'h3F000000, 32'h00000000, 3};

        // Reset state and first acceptance
        #12;
        check("reset i_ack", {31'd0, i_ack}, 32'd0);
        check("reset o_z_stb", {31'd0, o_z_stb}, 32'd0);
        check("reset o_z", o_z, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release i_ack", {31'd0, i_ack}, 32'd0);
        @(negedge clk);
        check("first i_ack", {31'd0, i_ack}, 32'd1);

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].z, vecs[i].lat, i % 3, i == 5);

        // Back-pressure: result held, upstream strobe ignored
        wait_i_ack("bp");
        ia    = 32'h40200000;
        i_stb = 1'b1;
        step();
        i_stb = 1'b1;
        ia    = 32'h41200000;
        c0    = cap_cnt;
        lat   = 0;
        while (!o_z_stb && lat < 100) begin
            step();
            lat++;
        end
        zv = o_z;
        check("bp value", zv, 32'd2);
        for (int k = 0; k < 20; k++) begin
            step();
            if (o_z !== zv || o_z_stb !== 1'b1 || i_ack !== 1'b0) begin
                n_errors++;
                $display("FAIL bp hold cycle %0d: o_z=%h stb=%b i_ack=%b", k, o_z, o_z_stb, i_ack);
            end
            n_checks++;
        end
        i_stb = 1'b0;
        check("bp no capture", cap_cnt, c0);
        o_z_ack = 1'b1;
        step();
        o_z_ack = 1'b0;
        check("bp stb drop", {31'd0, o_z_stb}, 32'd0);
        check("bp i_ack low", {31'd0, i_ack}, 32'd0);
        step();
        check("bp i_ack high", {31'd0, i_ack}, 32'd1);

        // Reset during convert discards the operand
        wait_i_ack("rst");
        o0    = out_cnt;
        ia    = 32'h3F800000;
        i_stb = 1'b1;
        step();
        i_stb = 1'b0;
        repeat (10) step();
        #2 rst = 1'b0;
        #1;
        check("rst o_z_stb", {31'd0, o_z_stb}, 32'd0);
        check("rst i_ack", {31'd0, i_ack}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) step();
        check("rst no output", out_cnt, o0);
        run_op("after rst", 32'h40A00000, 32'd5, 34, 1, 1'b0);

        // Upstream multiplier result 3.0 * -2.0 = -6.0
        c0 = cap_cnt;
        o0 = out_cnt;
        run_op("chain", 32'hC0C00000, 32'hFFFFFFFA, 34, 2, 1'b0);
        step();
        check("chain captures", cap_cnt - c0, 32'd1);
        check("chain outputs", out_cnt - o0, 32'd1);

        for (int i = 0; i < 150; i++) begin
            x = $urandom;
            if ($urandom_range(0, 1) == 1) x[30:23] = 8'($urandom_range(110, 165));
            run_op($sformatf("rand%0d %h", i, x), x, ref_z(x), ref_lat(x),
                   $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
